// File: rtl/usd_spi_pkg.sv
// Shared types and constants for the microSD SPI initiator.
// Optional feature macro used by this block: USD_SPI_RXREAD_EN.
package usd_spi_pkg;

  localparam int DIV_W = 4;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

endpackage

// File: rtl/usd_spi_tick.sv
// Programmable SCK half-period divider: tick fires every DIV enabled cycles,
// with the count restarted by the start of a transfer.
module usd_spi_tick
  import usd_spi_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_r;

  assign tick = enable && (cnt_r == {DIV_W{1'b0}});

  // Down-counter, reloaded on restart and on every tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= RELOAD;
    end else if (restart || tick) begin
      cnt_r <= RELOAD;
    end else if (enable) begin
      cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/usd_spi.sv
// Byte-wide SPI initiator (mode 0, MSB first) for the zx48 microSD lines.
// Define USD_SPI_RXREAD_EN to let rx_re start a 0xFF exchange.
module usd_spi
  import usd_spi_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs_we,
  input  logic       cs_d,
  input  logic       tx_we,
  input  logic [7:0] tx_d,
  input  logic       rx_re,
  output logic [7:0] rx_q,
  output logic       busy,
  output logic       done,
  output logic       usdCk,
  output logic       usdCs,
  output logic       usdMosi,
  input  logic       usdMiso
);

  state_e     state_r, state_s;
  logic [7:0] sr_r, sr_s;
  logic [2:0] bit_r, bit_s;
  logic       ck_r, ck_s;
  logic       cs_r, cs_s;
  logic       mosi_r, mosi_s;
  logic [7:0] rxq_r, rxq_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;

  logic       rx_start_s;
  logic       accept_s;
  logic [7:0] load_s;
  logic       tick_s;

`ifdef USD_SPI_RXREAD_EN
  assign rx_start_s = rx_re;
`else
  // Port kept for interface compatibility; reads never start a transfer
  assign rx_start_s = rx_re & 1'b0;
`endif

  assign accept_s = (state_r == IDLE) && (tx_we || rx_start_s);
  assign load_s   = tx_we ? tx_d : FILL_BYTE;

  usd_spi_tick #(
    .DIV (DIV)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (accept_s),
    .enable  (state_r != IDLE),
    .tick    (tick_s)
  );

  // Next-state and next-output logic; MISO is shifted in on the rising tick
  always_comb begin
    state_s = state_r;
    sr_s    = sr_r;
    bit_s   = bit_r;
    ck_s    = ck_r;
    mosi_s  = mosi_r;
    rxq_s   = rxq_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LO;
          sr_s    = load_s;
          mosi_s  = load_s[7];
          bit_s   = 3'd7;
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        if (tick_s) begin
          state_s = HI;
          ck_s    = 1'b1;
          sr_s    = {sr_r[6:0], usdMiso};
        end else begin
          state_s = LO;
        end
      end
      HI: begin
        if (tick_s) begin
          ck_s = 1'b0;
          if (bit_r == 3'd0) begin
            state_s = IDLE;
            rxq_s   = sr_r;
            done_s  = 1'b1;
            mosi_s  = 1'b1;
          end else begin
            state_s = LO;
            mosi_s  = sr_r[7];
            bit_s   = bit_r - 3'd1;
          end
        end else begin
          state_s = HI;
        end
      end
      default: begin
        state_s = IDLE;
        ck_s    = 1'b0;
        mosi_s  = 1'b1;
      end
    endcase
    busy_s = (state_s != IDLE);
    if (cs_we) begin
      cs_s = cs_d;
    end else begin
      cs_s = cs_r;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sr_r    <= 8'h00;
      bit_r   <= 3'd0;
      ck_r    <= 1'b0;
      cs_r    <= 1'b1;
      mosi_r  <= 1'b1;
      rxq_r   <= FILL_BYTE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      bit_r   <= bit_s;
      ck_r    <= ck_s;
      cs_r    <= cs_s;
      mosi_r  <= mosi_s;
      rxq_r   <= rxq_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign rx_q    = rxq_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign usdCk   = ck_r;
  assign usdCs   = cs_r;
  assign usdMosi = mosi_r;

endmodule

// File: tb/tb_usd_spi.sv
// Self-checking bench for usd_spi: cycle-by-cycle comparison against a
// timing model derived from the SCK schedule and the byte being exchanged.
module tb_usd_spi;

  localparam int DIV  = 2;
  localparam int XLEN = 16 * DIV;
`ifdef USD_SPI_RXREAD_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       cs_we, cs_d, tx_we, rx_re, usdMiso;
  logic [7:0] tx_d;
  logic [7:0] rx_q;
  logic       busy, done, usdCk, usdCs, usdMosi;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] rx_exp;
  logic       cs_exp;

  usd_spi #(.DIV(DIV)) dut (
    .clock   (clock),
    .reset   (reset),
    .cs_we   (cs_we),
    .cs_d    (cs_d),
    .tx_we   (tx_we),
    .tx_d    (tx_d),
    .rx_re   (rx_re),
    .rx_q    (rx_q),
    .busy    (busy),
    .done    (done),
    .usdCk   (usdCk),
    .usdCs   (usdCs),
    .usdMosi (usdMosi),
    .usdMiso (usdMiso)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ck"},   32'(usdCk),   32'd0);
    chk({tag, ".busy"}, 32'(busy),    32'd0);
    chk({tag, ".done"}, 32'(done),    32'd0);
    chk({tag, ".mosi"}, 32'(usdMosi), 32'd1);
    chk({tag, ".cs"},   32'(usdCs),   32'(cs_exp));
    chk({tag, ".rxq"},  32'(rx_q),    32'(rx_exp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      chk_idle("idle");
    end
  endtask

  // Called at a negedge; drives a start and follows the whole exchange.
  task automatic run_xfer(input bit via_rx, input bit both, input logic [7:0] txb,
                          input logic [7:0] misob, input int drop_at, input int abort_at);
    logic [7:0] sent;
    sent    = (via_rx && !both) ? 8'hFF : txb;
    tx_we   = !via_rx || both;
    rx_re   = via_rx;
    tx_d    = txb;
    usdMiso = misob[7];
    @(negedge clock);
    tx_we = 1'b0;
    rx_re = 1'b0;
    tx_d  = 8'($urandom);
    chk("x0.busy", 32'(busy),    32'd1);
    chk("x0.ck",   32'(usdCk),   32'd0);
    chk("x0.mosi", 32'(usdMosi), 32'(sent[7]));
    for (int c = 1; c <= XLEN; c++) begin
      if (c < XLEN) usdMiso = misob[7 - c / (2 * DIV)];
      if ($urandom_range(0, 5) == 0) begin
        cs_we  = 1'b1;
        cs_d   = 1'($urandom_range(0, 1));
        cs_exp = cs_d;
      end
      if (c == drop_at) begin
        tx_we = 1'b1;
        tx_d  = 8'($urandom);
      end
      @(negedge clock);
      tx_we = 1'b0;
      cs_we = 1'b0;
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        rx_exp = 8'hFF;
        cs_exp = 1'b1;
        chk("abort.ck",   32'(usdCk),   32'd0);
        chk("abort.cs",   32'(usdCs),   32'd1);
        chk("abort.mosi", 32'(usdMosi), 32'd1);
        chk("abort.rxq",  32'(rx_q),    32'hFF);
        chk("abort.busy", 32'(busy),    32'd0);
        return;
      end
      chk("x.ck",   32'(usdCk),   32'((c < XLEN) && (((c / DIV) % 2) == 1)));
      chk("x.mosi", 32'(usdMosi), (c < XLEN) ? 32'(sent[7 - c / (2 * DIV)]) : 32'd1);
      chk("x.busy", 32'(busy),    32'(c < XLEN));
      chk("x.done", 32'(done),    32'(c == XLEN));
      chk("x.cs",   32'(usdCs),   32'(cs_exp));
      chk("x.rxq",  32'(rx_q),    (c == XLEN) ? 32'(misob) : 32'(rx_exp));
    end
    rx_exp = misob;
  endtask

  initial begin
    logic [7:0] a, b;
    reset   = 1'b0;
    cs_we   = 1'b0;
    cs_d    = 1'b1;
    tx_we   = 1'b0;
    rx_re   = 1'b0;
    tx_d    = 8'h00;
    usdMiso = 1'b1;
    rx_exp  = 8'hFF;
    cs_exp  = 1'b1;
    repeat (3) @(negedge clock);
    chk_idle("rst");
    reset = 1'b1;
    idle(2);

    // Select the card, then the reference byte exchange
    cs_we = 1'b1; cs_d = 1'b0; cs_exp = 1'b0;
    @(negedge clock);
    cs_we = 1'b0;
    chk("cs.sel", 32'(usdCs), 32'd0);
    run_xfer(1'b0, 1'b0, 8'hA5, 8'h3C, -1, -1);
    chk("a5.rxq", 32'(rx_q), 32'h3C);
    idle(3);

    // Start while busy is dropped
    run_xfer(1'b0, 1'b0, 8'($urandom), 8'($urandom), 5, -1);
    idle(4);

    // tx_we and rx_re together: tx_d is sent
    run_xfer(1'b1, 1'b1, 8'h12, 8'($urandom), -1, -1);
    idle(2);

    if (RX_EN) begin
      usdMiso = 1'b0;
      run_xfer(1'b1, 1'b0, 8'($urandom), 8'h00, -1, -1);
      chk("rx.rxq", 32'(rx_q), 32'h00);
      idle(2);
    end else begin
      rx_re = 1'b1;
      @(negedge clock);
      rx_re = 1'b0;
      chk_idle("rxoff");
      idle(8);
    end

    // Back-to-back: second start in the done cycle
    a = 8'($urandom);
    b = 8'($urandom);
    run_xfer(1'b0, 1'b0, a, b, -1, -1);
    run_xfer(1'b0, 1'b0, b, a, -1, -1);
    idle(2);

    for (int i = 0; i < 10; i++) begin
      run_xfer(RX_EN && ($urandom_range(0, 2) == 0), 1'b0, 8'($urandom), 8'($urandom),
               ($urandom_range(0, 1) == 0) ? $urandom_range(1, XLEN - 1) : -1, -1);
      idle($urandom_range(1, 3));
    end

    // Async reset in the middle of a transfer
    run_xfer(1'b0, 1'b0, 8'($urandom), 8'h5A, -1, 10);
    @(negedge clock);
    chk_idle("inrst");
    reset = 1'b1;
    idle(XLEN + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
